// File: rtl/proc_pkg.sv
// Shared constants for the 1-to-2 demultiplexer and its output buffers.
package proc_pkg;

  // Default width of every data path.
  localparam int DATA_W_DEFAULT = 16;

  // Width of the per-output delivered-word counters (wrap modulo 256).
  localparam int CNT_W = 8;

  // Destination select encoding carried on in_sel.
  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO used as one output buffer of the demux.
// Pointers wrap modulo DEPTH (DEPTH is 2 or 4, so natural binary wrap).
// An occupancy counter gives full/empty directly.
module demux_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  input  logic              pop,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [OCC_W-1:0]  occ;
  logic              do_push;
  logic              do_pop;

  // Guard both operations so a misbehaving caller cannot corrupt the pointers.
  assign full    = (occ == OCC_W'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy update; reset discards all buffered words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage write; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/demux_1to2_16.sv
// 1-to-2 demultiplexer with a small FIFO per output and per-output
// delivered-word counters.
//
// Handshake: every interface uses valid/ready. A transfer happens on a rising
// edge where valid and ready are both high. valid never depends on ready.
// in_ready depends only on in_sel, rst_n and registered buffer state, never on
// in_valid, and each buffer isolates its sink so one stalled output cannot
// block words routed to the other.
module demux_1to2_16
  import proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic [CNT_W-1:0]  out0_cnt,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic [CNT_W-1:0]  out1_cnt
);

  logic full0;
  logic full1;
  logic empty0;
  logic empty1;
  logic sel_full;
  logic accept;
  logic push0;
  logic push1;
  logic pop0;
  logic pop1;

  // Readiness follows the selected buffer only; held low while in reset.
  assign sel_full = (in_sel == SEL_OUT1) ? full1 : full0;
  assign in_ready = rst_n & ~sel_full;
  assign accept   = in_valid & in_ready;
  assign push0    = accept & (in_sel == SEL_OUT0);
  assign push1    = accept & (in_sel == SEL_OUT1);

  assign out0_valid = ~empty0;
  assign out1_valid = ~empty1;
  assign pop0       = out0_valid & out0_ready;
  assign pop1       = out1_valid & out1_ready;

  demux_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (in_data),
    .full      (full0),
    .pop       (pop0),
    .empty     (empty0),
    .head      (out0_data)
  );

  demux_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .full      (full1),
    .pop       (pop1),
    .empty     (empty1),
    .head      (out1_data)
  );

  // Delivered-word counters; wrap naturally at 2**CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out0_cnt <= '0;
      out1_cnt <= '0;
    end else begin
      if (pop0) out0_cnt <= out0_cnt + CNT_W'(1);
      if (pop1) out1_cnt <= out1_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux_1to2_16.sv
// Self-checking bench for demux_1to2_16: directed scenarios plus a random
// soak, all compared against a queue-based model of the two output buffers.
module tb_demux_1to2_16;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 2;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sel;
  logic              out0_valid;
  logic              out0_ready;
  logic [DATA_W-1:0] out0_data;
  logic [7:0]        out0_cnt;
  logic              out1_valid;
  logic              out1_ready;
  logic [DATA_W-1:0] out1_data;
  logic [7:0]        out1_cnt;

  int n_vec;
  int n_err;

  // Reference model: one queue per output plus delivered counters.
  logic [DATA_W-1:0] exp_q0[$];
  logic [DATA_W-1:0] exp_q1[$];
  logic [7:0]        exp_cnt0;
  logic [7:0]        exp_cnt1;
  logic              model_acc;

  demux_1to2_16 #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_cnt   (out0_cnt),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_cnt   (out1_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected readiness: room in the selected queue and not in reset.
  function automatic logic exp_ready();
    if (!rst_n) return 1'b0;
    if (in_sel) return (exp_q1.size() < DEPTH);
    return (exp_q0.size() < DEPTH);
  endfunction

  // Model update at every rising edge from the spec's transfer rules.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      exp_cnt0 = 8'd0;
      exp_cnt1 = 8'd0;
    end else begin
      model_acc = in_valid && (in_sel ? (exp_q1.size() < DEPTH) : (exp_q0.size() < DEPTH));
      if (exp_q0.size() > 0 && out0_ready) begin
        void'(exp_q0.pop_front());
        exp_cnt0 = exp_cnt0 + 8'd1;
      end
      if (exp_q1.size() > 0 && out1_ready) begin
        void'(exp_q1.pop_front());
        exp_cnt1 = exp_cnt1 + 8'd1;
      end
      if (model_acc) begin
        if (in_sel) exp_q1.push_back(in_data);
        else        exp_q0.push_back(in_data);
      end
    end
  end

  // Driver: advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 16'h5555;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready cyc%0d: got %b want 0", c, in_ready); end
      n_vec++;
      if ({out0_valid, out1_valid} !== 2'b00) begin n_err++; $display("FAIL reset_valid cyc%0d: got %b%b want 00", c, out0_valid, out1_valid); end
      n_vec++;
      if ({out0_cnt, out1_cnt} !== 16'h0000) begin n_err++; $display("FAIL reset_cnt cyc%0d: got %h/%h want 00/00", c, out0_cnt, out1_cnt); end
    end
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    n_vec++;
    if ({out0_valid, out1_valid} !== 2'b00) begin n_err++; $display("FAIL release_valid: got %b%b want 00", out0_valid, out1_valid); end
    tick();
  endtask

  task automatic test_single_route();
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 16'hA5A5;
    out0_ready = 1'b1;
    out1_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out0_valid !== 1'b1 || out0_data !== 16'hA5A5) begin
      n_err++; $display("FAIL single_out0: got v=%b d=%h want v=1 d=a5a5", out0_valid, out0_data);
    end
    n_vec++;
    if (out1_valid !== 1'b0) begin n_err++; $display("FAIL single_out1_quiet: got %b want 0", out1_valid); end
    tick();
    @(negedge clk);
    n_vec++;
    if (out0_cnt !== 8'd1 || out0_valid !== 1'b0) begin
      n_err++; $display("FAIL single_cnt: got cnt=%0d v=%b want cnt=1 v=0", out0_cnt, out0_valid);
    end
    tick();
  endtask

  task automatic test_fill_stall();
    logic [DATA_W-1:0] got[$];
    logic              accept_now;
    logic              third_taken;
    out0_ready  = 1'b0;
    out1_ready  = 1'b0;
    third_taken = 1'b0;
    for (int w = 1; w <= 3; w++) begin
      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_data  = DATA_W'(w);
      @(negedge clk);
      n_vec++;
      if (in_ready !== (w < 3)) begin n_err++; $display("FAIL fill_in_ready w%0d: got %b want %b", w, in_ready, (w < 3)); end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0 || out0_valid !== 1'b1 || out0_data !== 16'h0001) begin
      n_err++; $display("FAIL stall_hold: got rdy=%b v=%b d=%h want rdy=0 v=1 d=0001", in_ready, out0_valid, out0_data);
    end
    tick();
    out0_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out0_valid && out0_ready) got.push_back(out0_data);
      accept_now = in_valid && in_ready;
      tick();
      if (accept_now) begin
        in_valid    = 1'b0;
        third_taken = 1'b1;
      end
    end
    n_vec++;
    if (third_taken !== 1'b1) begin n_err++; $display("FAIL drain_third_accept: got %b want 1", third_taken); end
    n_vec++;
    if (got.size() != 3) begin
      n_err++; $display("FAIL drain_count: got %0d want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (got[i] !== DATA_W'(i + 1)) begin n_err++; $display("FAIL drain_order[%0d]: got %h want %h", i, got[i], DATA_W'(i + 1)); end
      end
    end
  endtask

  task automatic test_isolation();
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_data  = DATA_W'($urandom);
      tick();
    end
    in_sel  = 1'b1;
    in_data = 16'h1234;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL iso_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out1_valid !== 1'b1 || out1_data !== 16'h1234) begin
      n_err++; $display("FAIL iso_out1: got v=%b d=%h want v=1 d=1234", out1_valid, out1_data);
    end
    n_vec++;
    if (out0_valid !== 1'b1) begin n_err++; $display("FAIL iso_out0_held: got %b want 1", out0_valid); end
    tick();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    int seen0;
    int seen1;
    do_reset();
    seen0      = 0;
    seen1      = 0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_valid = (i < 20);
      in_sel   = i[0];
      in_data  = DATA_W'($urandom);
      @(negedge clk);
      if (i < 20) begin
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_bubble i%0d: got %b want 1", i, in_ready); end
      end
      if (exp_q0.size() > 0) begin
        n_vec++;
        if (out0_valid !== 1'b1 || out0_data !== exp_q0[0]) begin
          n_err++; $display("FAIL b2b_out0 i%0d: got v=%b d=%h want v=1 d=%h", i, out0_valid, out0_data, exp_q0[0]);
        end
      end
      if (exp_q1.size() > 0) begin
        n_vec++;
        if (out1_valid !== 1'b1 || out1_data !== exp_q1[0]) begin
          n_err++; $display("FAIL b2b_out1 i%0d: got v=%b d=%h want v=1 d=%h", i, out1_valid, out1_data, exp_q1[0]);
        end
      end
      if (out0_valid && out0_ready) seen0++;
      if (out1_valid && out1_ready) seen1++;
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (seen0 != 10 || seen1 != 10) begin n_err++; $display("FAIL b2b_words: got %0d/%0d want 10/10", seen0, seen1); end
    n_vec++;
    if (out0_cnt !== 8'd10 || out1_cnt !== 8'd10) begin n_err++; $display("FAIL b2b_cnt: got %0d/%0d want 10/10", out0_cnt, out1_cnt); end
    tick();
  endtask

  task automatic test_wrap_mid_reset();
    do_reset();
    out0_ready = 1'b0;
    out1_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      in_valid = 1'b1;
      in_sel   = 1'b1;
      in_data  = DATA_W'($urandom);
      @(negedge clk);
      if (in_ready !== 1'b1) begin
        n_vec++; n_err++; $display("FAIL wrap_in_ready i%0d: got %b want 1", i, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_vec++;
    if (out1_cnt !== 8'd1 || out1_valid !== 1'b0) begin
      n_err++; $display("FAIL wrap_cnt: got cnt=%0d v=%b want cnt=1 v=0", out1_cnt, out1_valid);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_data  = 16'hBEE0 + DATA_W'(i);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out0_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_out0: got %b want 1", out0_valid); end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
    tick();
    rst_n      = 1'b1;
    out0_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++;
      if (out0_valid !== 1'b0 || out0_cnt !== 8'd0 || out1_cnt !== 8'd0) begin
        n_err++; $display("FAIL midrst_discard c%0d: got v=%b cnt=%0d/%0d want v=0 cnt=0/0", c, out0_valid, out0_cnt, out1_cnt);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      in_valid   = $urandom_range(0, 1);
      in_sel     = $urandom_range(0, 1);
      in_data    = DATA_W'($urandom);
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      n_vec++;
      if (in_ready !== exp_ready()) begin n_err++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, exp_ready()); end
      n_vec++;
      if (out0_valid !== (exp_q0.size() > 0) || out1_valid !== (exp_q1.size() > 0)) begin
        n_err++; $display("FAIL rnd_valid c%0d: got %b%b want %b%b", c, out0_valid, out1_valid, (exp_q0.size() > 0), (exp_q1.size() > 0));
      end
      if (exp_q0.size() > 0) begin
        n_vec++;
        if (out0_data !== exp_q0[0]) begin n_err++; $display("FAIL rnd_out0_data c%0d: got %h want %h", c, out0_data, exp_q0[0]); end
      end
      if (exp_q1.size() > 0) begin
        n_vec++;
        if (out1_data !== exp_q1[0]) begin n_err++; $display("FAIL rnd_out1_data c%0d: got %h want %h", c, out1_data, exp_q1[0]); end
      end
      n_vec++;
      if (out0_cnt !== exp_cnt0 || out1_cnt !== exp_cnt1) begin
        n_err++; $display("FAIL rnd_cnt c%0d: got %0d/%0d want %0d/%0d", c, out0_cnt, out1_cnt, exp_cnt0, exp_cnt1);
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    test_reset();
    test_single_route();
    test_fill_stall();
    test_isolation();
    test_back_to_back();
    test_wrap_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux_1to2_16.md
DEMUX_1TO2_16 -- requirements
Module: demux_1to2_16

Interface
REQ-001 Parameter: DATA_W, default 16, width of every data path.
REQ-002 Parameter: DEPTH, default 2, entries per output buffer; legal values are 2 and 4 only.
REQ-003 Port: clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 Port: rst_n, input, 1, reset: synchronous, active-low, sampled on the rising edge of clk.
REQ-005 Port: in_valid, input, 1, source offers a word.
REQ-006 Port: in_ready, output, 1, block accepts the offered word this cycle.
REQ-007 Port: in_data, input, DATA_W, word to be routed.
REQ-008 Port: in_sel, input, 1, destination select: 0 routes to out0, 1 routes to out1.
REQ-009 Port: out0_valid / out1_valid, output, 1 each, the buffer head is presented.
REQ-010 Port: out0_ready / out1_ready, input, 1 each, the sink takes the head this cycle.
REQ-011 Port: out0_data / out1_data, output, DATA_W each, buffer head word.
REQ-012 Port: out0_cnt / out1_cnt, output, 8 each, count of words delivered per output, wrapping modulo 256.

Function
REQ-013 Input transfer: an input transfer occurs when in_valid and in_ready are both high on a rising edge.
REQ-014 in_ready timing: in_ready = NOT full(buffer[in_sel]); in_ready is combinational on in_sel and registered buffer state only, never on in_valid.
REQ-015 Routing: each accepted word is written into buffer[in_sel] only; the other buffer is unchanged.
REQ-016 Output transfer: an output transfer occurs on outN when outN_valid and outN_ready are both high; the head is popped on that edge.
REQ-017 Latency: a word accepted into an empty buffer appears on outN_data with outN_valid high in the next cycle. There is no combinational in->out path.
REQ-018 outN_valid = NOT empty(bufferN); outN_data holds the oldest unpopped word and is stable while outN_valid is high and outN_ready is low.
REQ-019 Ordering: words keep FIFO order per output; no ordering is guaranteed between out0 and out1.
REQ-020 Simultaneous push and pop on the same buffer: both complete in one cycle and occupancy is unchanged. This is legal when full only if a pop is pending? No — in_ready is still low when full (REQ-014); a full buffer accepts no push even if its sink is ready that cycle.
REQ-021 Buffer state: each buffer keeps rd/wr pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter of 0..DEPTH; full = (occ == DEPTH), empty = (occ == 0).
REQ-022 Counters: outN_cnt increments by 1 on each outN transfer, and 255 wraps to 0.
REQ-023 Head-of-line isolation: a stalled out0 (out0_ready low, buffer full) shall not block words selected for out1, and out1 shall not block out0.
REQ-024 Protocol rule: in_data and in_sel are don't-care while in_valid is low. The source may change in_sel while in_valid is high and not accepted; in_ready follows in_sel combinationally.

Reset
REQ-025 Reset values: while rst_n is low at a clock edge, all pointers, occupancy and counters clear to 0, so out0_valid = out1_valid = 0, out0_cnt = out1_cnt = 0, and in_ready = 1 after the first non-reset edge.
REQ-026 Reset mid-operation: buffered words are discarded, with no output transfer reported for them and counters not incremented. outN_data content after reset is don't-care.
REQ-027 in_ready during reset: in_ready shall be 0 during any cycle in which rst_n is low.

Structure
REQ-028 Shared package proc_pkg: holds DATA_W_DEFAULT = 16, CNT_W = 8, and the select encoding constants SEL_OUT0 = 1'b0, SEL_OUT1 = 1'b1.
REQ-029 Sub-module: a single sub-module demux_fifo (DATA_W, DEPTH; push/full, pop/empty, head data) shall be instantiated twice. Routing logic and counters stay in the top level.

Verification
REQ-030 Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, both valid = 0, both cnt = 0; first cycle after release -> in_ready = 1.
REQ-031 Single route: push 0xA5A5 with in_sel = 0 and out0_ready = 1 -> out0_valid high with 0xA5A5 exactly one cycle later, out1_valid stays 0, out0_cnt = 1.
REQ-032 Fill and stall: out0_ready = 0; push 0x0001, 0x0002, 0x0003 to out0 (DEPTH = 2) -> third word not accepted (in_ready = 0); raise out0_ready -> 0x0001, then 0x0002, then 0x0003 in order.
REQ-033 Isolation: out0 full and stalled; push 0x1234 with in_sel = 1 -> accepted immediately and 0x1234 appears on out1 next cycle.
REQ-034 Full-rate: both readys high; alternate sel 0/1 with 20 back-to-back words -> no bubbles on in_ready, 10 words on each output, cnt = 10 each.
REQ-035 Wrap and mid-reset: 257 transfers to out1 -> out1_cnt = 1. Then with out0 holding 2 words, pulse rst_n low for 1 cycle -> out0_valid = 0, out0_cnt = 0, and the old words never emerge.
